// File: rtl/axi_lite_master_bridge_if.sv
// Bundles the CPU-side request/response port and the AXI4-Lite master channels.
// The bridge connects through the master modport; the CPU and peripheral side connect through the slave modport.
interface axi_lite_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic              busy;

    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [2:0]        m_axi_awprot;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [2:0]        m_axi_arprot;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding CPU request to AXI4-Lite master bridge with a response-phase
// timeout; a timed-out transaction is drained so the late slave response is swallowed.
module axi_lite_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input logic                     s_axi_aclk,
    input logic                     s_axi_aresetn,
    axi_lite_master_bridge_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        DONE,
        DRAIN
    } state_e;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, expired;

    assign aw_hs   = awvalid_q && bus.m_axi_awready;
    assign w_hs    = wvalid_q  && bus.m_axi_wready;
    assign b_hs    = bready_q  && bus.m_axi_bvalid;
    assign ar_hs   = arvalid_q && bus.m_axi_arready;
    assign r_hs    = rready_q  && bus.m_axi_rvalid;
    assign expired = (TIMEOUT > 0) && (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d      = bus.req_we;
                    addr_d    = bus.req_addr;
                    wdata_d   = bus.req_wdata;
                    wstrb_d   = bus.req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.req_we ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q  || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_B;
                    cnt_d   = '0;
                end
            end
            WR_B: begin
                // A handshake in the expiry cycle still counts as a normal response.
                if (b_hs) begin
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = bus.m_axi_bresp;
                    rsp_timeout_d = 1'b0;
                end else if (expired) begin
                    state_d       = DRAIN;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_AR: begin
                if (ar_hs) begin
                    state_d = RD_R;
                    cnt_d   = '0;
                end
            end
            RD_R: begin
                if (r_hs) begin
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = bus.m_axi_rdata;
                    rsp_resp_d    = bus.m_axi_rresp;
                    rsp_timeout_d = 1'b0;
                end else if (expired) begin
                    state_d       = DRAIN;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            DRAIN: begin
                // The late response is consumed silently so the slave is left idle.
                if (we_q ? b_hs : r_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        awvalid_d   = (state_d == WR_AW_W) && !aw_done_d;
        wvalid_d    = (state_d == WR_AW_W) && !w_done_d;
        arvalid_d   = (state_d == RD_AR);
        bready_d    = (state_d == WR_B) || ((state_d == DRAIN) &&  we_d);
        rready_d    = (state_d == RD_R) || ((state_d == DRAIN) && !we_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.busy          = busy_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: a delay-programmable AXI4-Lite slave with its own memory,
// and a transaction-level reference model predicting response, latency and memory contents.
module tb_axi_lite_master_bridge;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .bus          (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave behaviour for the current transaction.
    int         cfg_awdly = 0, cfg_wdly = 0, cfg_ardly = 0, cfg_bdly = 0, cfg_rdly = 0;
    logic [1:0] cfg_resp = 2'b00;

    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];

    logic        aw_got, w_got, ar_got;
    int          aw_age, w_age, ar_age, b_age, r_age;
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0]  w_s;

    task automatic slave_clear();
        aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
    endtask

    task automatic slave_drive();
        if (!rst_n) begin
            bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_arready = 1'b0;
            bus.m_axi_bvalid  = 1'b0; bus.m_axi_rvalid = 1'b0;
            return;
        end
        if (bus.m_axi_awvalid && !aw_got) begin
            bus.m_axi_awready = (aw_age >= cfg_awdly); aw_age++;
        end else bus.m_axi_awready = 1'b0;
        if (bus.m_axi_wvalid && !w_got) begin
            bus.m_axi_wready = (w_age >= cfg_wdly); w_age++;
        end else bus.m_axi_wready = 1'b0;
        if (bus.m_axi_arvalid && !ar_got) begin
            bus.m_axi_arready = (ar_age >= cfg_ardly); ar_age++;
        end else bus.m_axi_arready = 1'b0;
        if (aw_got && w_got) begin
            bus.m_axi_bvalid = (b_age >= cfg_bdly); b_age++;
            bus.m_axi_bresp  = cfg_resp;
        end else bus.m_axi_bvalid = 1'b0;
        if (ar_got) begin
            bus.m_axi_rvalid = (r_age >= cfg_rdly); r_age++;
            bus.m_axi_rdata  = slv_mem[ar_a[5:2]];
            bus.m_axi_rresp  = cfg_resp;
        end else bus.m_axi_rvalid = 1'b0;
    endtask

    task automatic slave_sample();
        if (!rst_n) begin
            slave_clear();
            return;
        end
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin aw_got = 1'b1; aw_a = bus.m_axi_awaddr; end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
            w_got = 1'b1; w_d = bus.m_axi_wdata; w_s = bus.m_axi_wstrb;
        end
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin ar_got = 1'b1; ar_a = bus.m_axi_araddr; end
        if (bus.m_axi_bvalid && bus.m_axi_bready) begin
            for (int b = 0; b < 4; b++)
                if (w_s[b]) slv_mem[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
            slave_clear();
        end
        if (bus.m_axi_rvalid && bus.m_axi_rready) slave_clear();
    endtask

    initial begin
        slave_clear();
        bus.m_axi_bresp = 2'b00; bus.m_axi_rresp = 2'b00; bus.m_axi_rdata = '0;
        forever begin
            @(negedge clk);
            slave_drive();
            @(posedge clk);
            slave_sample();
        end
    end

    // Issues one request and checks it against the transaction-level expectation.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
        int wd, lat, exp_lat, maxd, dly, cyc, stray;
        logic tmo;
        logic [1:0] exp_resp;
        logic [31:0] exp_rdata;

        maxd      = we ? ((cfg_awdly > cfg_wdly) ? cfg_awdly : cfg_wdly) : cfg_ardly;
        dly       = we ? cfg_bdly : cfg_rdly;
        tmo       = (dly >= TO);
        exp_lat   = tmo ? 2 + maxd + TO : 3 + maxd + dly;
        exp_resp  = tmo ? 2'b10 : cfg_resp;
        exp_rdata = we ? 32'h0 : ref_mem[addr[5:2]];
        if (we)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) ref_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];

        wd = 0;
        while (!bus.req_ready && wd < 200) begin @(negedge clk); wd++; end
        check("req_ready_before", bus.req_ready, 1'b1);
        if (!bus.req_ready) return;

        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_wstrb = wstrb;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.req_valid = 1'b0;
                check("req_ready_t1", bus.req_ready, 1'b0);
                check("busy_t1", bus.busy, 1'b1);
            end
            if (lat <= 1 + maxd) begin
                if (we) begin
                    check("awvalid_hold", bus.m_axi_awvalid, (lat - 1 <= cfg_awdly));
                    check("wvalid_hold", bus.m_axi_wvalid, (lat - 1 <= cfg_wdly));
                end else begin
                    check("arvalid_hold", bus.m_axi_arvalid, 1'b1);
                end
            end
            if (lat == 2 + maxd)
                check(we ? "bready_on" : "rready_on", we ? bus.m_axi_bready : bus.m_axi_rready, 1'b1);
        end while (!bus.rsp_valid && lat < 300);

        check("latency", lat, exp_lat);
        check("rsp_resp", bus.rsp_resp, exp_resp);
        check("rsp_timeout", bus.rsp_timeout, tmo);
        check("req_ready_at_rsp", bus.req_ready, 1'b0);
        if (!tmo) check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        else      check("busy_draining", bus.busy, 1'b1);

        @(negedge clk);
        cyc = lat + 1;
        check("single_pulse", bus.rsp_valid, 1'b0);
        check("rsp_resp_hold", bus.rsp_resp, exp_resp);
        if (!tmo) begin
            check("req_ready_after", bus.req_ready, 1'b1);
        end else begin
            stray = 0;
            while (!bus.req_ready && cyc < 400) begin
                @(negedge clk);
                cyc++;
                if (bus.rsp_valid) stray++;
            end
            check("drain_end", cyc, 3 + maxd + dly);
            check("drain_no_pulse", stray, 0);
        end
        check("busy_idle", bus.busy, 1'b0);
        if (we) begin
            check("awaddr", aw_a, addr);
            check("wdata", w_d, wdata);
            check("wstrb", w_s, wstrb);
        end else begin
            check("araddr", ar_a, addr);
        end
    endtask

    task automatic set_cfg(input int aw, input int w, input int ar, input int b, input int r,
                           input logic [1:0] resp);
        cfg_awdly = aw; cfg_wdly = w; cfg_ardly = ar; cfg_bdly = b; cfg_rdly = r; cfg_resp = resp;
    endtask

    initial begin
        int d;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        slv_mem[4] = 32'h0000_00A5;
        ref_mem[4] = 32'h0000_00A5;

        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_awvalid", bus.m_axi_awvalid, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        rst_n = 1'b1;
        #1 check("req_ready_at_release", bus.req_ready, 1'b0);
        @(negedge clk);
        check("req_ready_1cyc", bus.req_ready, 1'b1);

        set_cfg(0, 0, 0, 0, 0, 2'b00);
        do_txn(1'b1, 32'h0C, 32'h0000_0001, 4'hF);
        set_cfg(0, 1, 0, 0, 0, 2'b00);
        do_txn(1'b1, 32'h14, 32'hDEAD_BEEF, 4'h5);
        set_cfg(0, 0, 0, 0, 5, 2'b00);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0);
        set_cfg(0, 0, 0, 0, 0, 2'b10);
        do_txn(1'b0, 32'h18, 32'h0, 4'h0);
        set_cfg(0, 0, 0, 0, 0, 2'b00);
        do_txn(1'b0, 32'h0C, 32'h0, 4'h0);
        set_cfg(0, 0, 0, 40, 0, 2'b00);
        do_txn(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        set_cfg(0, 0, 0, 0, 15, 2'b01);
        do_txn(1'b0, 32'h20, 32'h0, 4'h0);

        // Reset while a read address is still waiting for ARREADY.
        set_cfg(0, 0, 10, 0, 0, 2'b00);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h24;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("arvalid_before_rst", bus.m_axi_arvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_arvalid", bus.m_axi_arvalid, 1'b0);
        check("mid_rst_req_ready", bus.req_ready, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_rsp_resp", bus.rsp_resp, 2'b00);
        check("mid_rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        check("mid_rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rerelease_req_ready", bus.req_ready, 1'b0);
        d = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) d++;
        end
        check("post_rst_req_ready", bus.req_ready, 1'b1);
        check("post_rst_no_rsp", d, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       d = 15;
                1:       d = 16;
                2:       d = 40;
                default: d = $urandom_range(0, 5);
            endcase
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), d, d,
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            do_txn(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                   $urandom, 4'($urandom_range(1, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
